// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared types and constants for the USB transmit serialiser.
//   tx_state_t         : transmitter FSM states
//   J / K / SE0        : bus line states encoded as {dp, dm}
//   *_DEF              : default values for the serialiser parameters
// ---------------------------------------------------------------------------
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        STUFF   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } tx_state_t;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    localparam int SYNC_BITS_DEF      = 8;
    localparam int STUFF_LIMIT_DEF    = 6;
    localparam int EOP_SE0_CYCLES_DEF = 2;

endpackage

// File: rtl/usb_nrzi_enc.sv
// ---------------------------------------------------------------------------
// usb_nrzi_enc
// NRZI line encoder with registered bus outputs. Holds the current NRZI
// level and the {dp, dm, out_en} output registers; every value appears on
// the wires the cycle after the edge that encoded it.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   nrz_bit      : unencoded bit to emit when bit_en is set
//   bit_en       : encode nrz_bit this cycle (0 = hold the line level)
//   force_se0    : drive SE0, NRZI level untouched
//   force_j      : drive J and reset the NRZI level to J
//   drive        : host owns the bus (becomes out_en)
//   dp, dm       : D+ / D- wire values
//   out_en       : output enable for the bus drivers
// ---------------------------------------------------------------------------
module usb_nrzi_enc
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic nrz_bit,
    input  logic bit_en,
    input  logic force_se0,
    input  logic force_j,
    input  logic drive,
    output logic dp,
    output logic dm,
    output logic out_en
);

    // level = 1 means the line idles at J, 0 means K
    logic       level;
    logic       level_next;
    logic [1:0] line;

    // NRZI: a zero toggles the level, a one holds it
    assign level_next = nrz_bit ? level : ~level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= 1'b1;
            line   <= J;
            out_en <= 1'b0;
        end else begin
            out_en <= drive;
            if (force_se0) begin
                line <= SE0;
            end else if (force_j) begin
                level <= 1'b1;
                line  <= J;
            end else if (bit_en) begin
                level <= level_next;
                line  <= level_next ? J : K;
            end else begin
                line <= level ? J : K;
            end
        end
    end

    assign dp = line[1];
    assign dm = line[0];

endmodule

// File: rtl/usb_tx_bitstuff_nrzi.sv
// ---------------------------------------------------------------------------
// usb_tx_bitstuff_nrzi
// Transmit-side serialiser: takes a bit-serial packet body (LSB-first) over
// a valid/ready handshake, prepends SYNC, bit-stuffs, NRZI-encodes and
// appends EOP (SE0 x EOP_SE0_CYCLES, then J). One bit time per clk.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   in_bit     : next unencoded packet bit
//   in_valid   : in_bit valid; starts a packet when idle
//   in_last    : in_bit is the final packet bit
//   in_ready   : bit accepted on this edge when in_valid is high
//   dp, dm     : D+ / D- lines (registered)
//   out_en     : host driving the bus (registered)
//   busy       : transmitter not idle
//   underrun   : one-cycle pulse when in_valid dropped mid-packet
//
// state   | meaning
// IDLE    | bus released, line at J, waiting for in_valid
// SYNC    | emitting SYNC_BITS-1 zeros then a one
// DATA    | accepting and encoding packet bits
// STUFF   | emitting an inserted zero after STUFF_LIMIT ones
// EOP_SE0 | driving SE0
// EOP_J   | driving J for one bit time, then release
// ---------------------------------------------------------------------------
module usb_tx_bitstuff_nrzi
    import usb_pkg::*;
#(
    parameter int SYNC_BITS      = SYNC_BITS_DEF,
    parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF,
    parameter int EOP_SE0_CYCLES = EOP_SE0_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    output logic dp,
    output logic dm,
    output logic out_en,
    output logic busy,
    output logic underrun
);

    localparam int MAX_CNT = (SYNC_BITS > EOP_SE0_CYCLES) ? SYNC_BITS : EOP_SE0_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0] SE0_END  = CNT_W'(EOP_SE0_CYCLES - 1);
    localparam logic [2:0]       ONES_MAX = 3'(STUFF_LIMIT);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ones;
    logic [2:0]       ones_inc;
    logic             last_pend;

    logic enc_bit;
    logic enc_bit_en;
    logic enc_se0;
    logic enc_j;
    logic enc_drive;

    assign in_ready = (state == DATA);
    assign busy     = (state != IDLE);
    assign ones_inc = ones + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ones      <= 3'd0;
            last_pend <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    ones      <= 3'd0;
                    last_pend <= 1'b0;
                    if (in_valid) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (cnt == SYNC_END) begin
                        cnt   <= '0;
                        // the trailing SYNC one starts the run of ones
                        ones  <= 3'd1;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (!in_valid) begin
                        underrun <= 1'b1;
                        ones     <= 3'd0;
                        state    <= EOP_SE0;
                    end else if (in_bit) begin
                        ones <= ones_inc;
                        if (ones_inc == ONES_MAX) begin
                            // remember in_last so EOP follows the stuffed zero
                            last_pend <= in_last;
                            state     <= STUFF;
                        end else if (in_last) begin
                            state <= EOP_SE0;
                        end
                    end else begin
                        ones <= 3'd0;
                        if (in_last) begin
                            state <= EOP_SE0;
                        end
                    end
                end
                STUFF: begin
                    ones      <= 3'd0;
                    last_pend <= 1'b0;
                    state     <= last_pend ? EOP_SE0 : DATA;
                end
                EOP_SE0: begin
                    if (cnt == SE0_END) begin
                        cnt   <= '0;
                        state <= EOP_J;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EOP_J: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        enc_bit    = 1'b0;
        enc_bit_en = 1'b0;
        enc_se0    = 1'b0;
        enc_j      = 1'b0;
        enc_drive  = 1'b0;
        case (state)
            IDLE: begin
                enc_j = 1'b1;
            end
            SYNC: begin
                enc_bit    = (cnt == SYNC_END);
                enc_bit_en = 1'b1;
                enc_drive  = 1'b1;
            end
            DATA: begin
                // an underrun cycle emits nothing; the line holds its level
                enc_bit    = in_bit;
                enc_bit_en = in_valid;
                enc_drive  = 1'b1;
            end
            STUFF: begin
                enc_bit    = 1'b0;
                enc_bit_en = 1'b1;
                enc_drive  = 1'b1;
            end
            EOP_SE0: begin
                enc_se0   = 1'b1;
                enc_drive = 1'b1;
            end
            EOP_J: begin
                enc_j     = 1'b1;
                enc_drive = 1'b1;
            end
            default: begin
                enc_j = 1'b1;
            end
        endcase
    end

    usb_nrzi_enc u_nrzi_enc (
        .clk       (clk),
        .rst       (rst),
        .nrz_bit   (enc_bit),
        .bit_en    (enc_bit_en),
        .force_se0 (enc_se0),
        .force_j   (enc_j),
        .drive     (enc_drive),
        .dp        (dp),
        .dm        (dm),
        .out_en    (out_en)
    );

endmodule

// File: tb/tb_usb_tx_bitstuff_nrzi.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_bitstuff_nrzi
// Self-checking bench: directed packets from the test plan plus randomized
// packets, compared against a reference model that builds the expected
// wire symbol sequence from the SYNC / stuffing / NRZI / EOP rules.
// ---------------------------------------------------------------------------
module tb_usb_tx_bitstuff_nrzi;

    localparam int SYM_SE0 = 0;
    localparam int SYM_K   = 1;
    localparam int SYM_J   = 2;

    logic clk = 1'b0;
    logic rst;
    logic in_bit;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic dp;
    logic dm;
    logic out_en;
    logic busy;
    logic underrun;

    always #5 clk = ~clk;

    usb_tx_bitstuff_nrzi dut (
        .clk      (clk),
        .rst      (rst),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .dp       (dp),
        .dm       (dm),
        .out_en   (out_en),
        .busy     (busy),
        .underrun (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit q_bits[$];
    bit q_last[$];

    int exp_sym[$];
    int exp_len[$];
    int exp_ready;
    int exp_under;
    int exp_gaps;

    int obs_sym[$];
    int obs_len[$];
    int obs_gap[$];
    int obs_ready;
    int obs_under;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Expected wire symbols for one packet; abort_after >= 0 means in_valid
    // drops once abort_after bits have been accepted.
    function automatic void model_packet(input bit pk[$], input int abort_after);
        bit logical[$];
        int run;
        int lvl;
        int nb;
        int len;
        for (int i = 0; i < 7; i++) logical.push_back(1'b0);
        logical.push_back(1'b1);
        run = 1;
        nb  = (abort_after >= 0) ? abort_after : pk.size();
        for (int i = 0; i < nb; i++) begin
            logical.push_back(pk[i]);
            run = pk[i] ? run + 1 : 0;
            if (run == 6) begin
                logical.push_back(1'b0);
                run = 0;
            end
        end
        lvl = SYM_J;
        foreach (logical[i]) begin
            if (!logical[i]) lvl = (lvl == SYM_J) ? SYM_K : SYM_J;
            exp_sym.push_back(lvl);
        end
        len = logical.size();
        if (abort_after >= 0) begin
            exp_sym.push_back(lvl);
            len++;
        end
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_J);
        exp_len.push_back(len + 3);
        exp_ready += nb + ((abort_after >= 0) ? 1 : 0);
        exp_under += (abort_after >= 0) ? 1 : 0;
    endfunction

    task automatic add_packet(input bit pk[$], input int abort_after);
        foreach (pk[i]) begin
            q_bits.push_back(pk[i]);
            q_last.push_back(i == pk.size() - 1);
        end
        model_packet(pk, abort_after);
    endtask

    function automatic void word_to_q(input logic [31:0] w, input int n, output bit pk[$]);
        pk = {};
        for (int i = 0; i < n; i++) pk.push_back(w[i]);
    endfunction

    function automatic void clear_all();
        q_bits = {}; q_last = {};
        exp_sym = {}; exp_len = {}; exp_ready = 0; exp_under = 0; exp_gaps = 0;
        obs_sym = {}; obs_len = {}; obs_gap = {}; obs_ready = 0; obs_under = 0;
    endfunction

    // Called 1 time unit after a rising edge; returns at the same alignment.
    task automatic run_stream(input int abort_at, input int rst_at);
        int  idx = 0;
        bit  done = 0;
        bit  seen_busy = 0;
        bit  prev_oe = 0;
        int  gap = 0;
        int  cur_len = 0;
        int  cyc = 0;
        bit  ended = 0;
        while (cyc < 3000 && !ended) begin
            if (out_en) begin
                obs_sym.push_back(int'({dp, dm}));
                cur_len++;
            end else if (prev_oe) begin
                obs_len.push_back(cur_len);
                cur_len = 0;
            end
            prev_oe = out_en;
            if (in_ready) obs_ready++;
            if (underrun) obs_under++;
            if (busy) begin
                if (seen_busy && gap > 0) obs_gap.push_back(gap);
                seen_busy = 1;
                gap = 0;
            end else if (seen_busy) begin
                gap++;
            end
            if (done && !busy && !out_en) begin
                ended = 1;
            end else begin
                if (!done && idx < q_bits.size()) begin
                    if (idx == rst_at && in_ready) begin
                        in_valid = 1'b0;
                        #2 rst = 1'b1;
                        #1;
                        chk("rst_dp", int'(dp), 1);
                        chk("rst_dm", int'(dm), 0);
                        chk("rst_out_en", int'(out_en), 0);
                        chk("rst_busy", int'(busy), 0);
                        chk("rst_in_ready", int'(in_ready), 0);
                        @(posedge clk);
                        @(negedge clk);
                        rst = 1'b0;
                        done = 1;
                    end else if (idx == abort_at && in_ready) begin
                        in_valid = 1'b0;
                        done = 1;
                    end else begin
                        in_valid = 1'b1;
                        in_bit   = q_bits[idx];
                        in_last  = q_last[idx];
                        if (in_ready) idx++;
                    end
                end else begin
                    done     = 1;
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                    in_last  = 1'($urandom);
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!ended) chk("cycle_budget_expired", cyc, -1);
        if (prev_oe) obs_len.push_back(cur_len);
    endtask

    task automatic compare_run(input string name);
        int n;
        chk({name, "_n_pkts"}, obs_len.size(), exp_len.size());
        n = (obs_len.size() < exp_len.size()) ? obs_len.size() : exp_len.size();
        for (int i = 0; i < n; i++) chk({name, "_oe_cycles"}, obs_len[i], exp_len[i]);
        chk({name, "_n_syms"}, obs_sym.size(), exp_sym.size());
        n = (obs_sym.size() < exp_sym.size()) ? obs_sym.size() : exp_sym.size();
        for (int i = 0; i < n; i++) chk({name, "_sym"}, obs_sym[i], exp_sym[i]);
        chk({name, "_ready_cycles"}, obs_ready, exp_ready);
        chk({name, "_underruns"}, obs_under, exp_under);
        chk({name, "_n_busy_gaps"}, obs_gap.size(), exp_gaps);
        foreach (obs_gap[i]) chk({name, "_busy_gap"}, obs_gap[i], 1);
        clear_all();
    endtask

    initial begin
        bit pk[$];
        int n;
        int ab;

        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        clear_all();
        #1;
        chk("reset_dp", int'(dp), 1);
        chk("reset_dm", int'(dm), 0);
        chk("reset_out_en", int'(out_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_underrun", int'(underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ACK 0xD2
        word_to_q(32'hD2, 8, pk);
        add_packet(pk, -1);
        run_stream(-1, -1);
        if (obs_len.size() > 0) chk("ack_oe_19", obs_len[0], 19);
        chk("ack_ready_8", obs_ready, 8);
        if (obs_sym.size() >= 8) begin
            chk("ack_sync0_K", obs_sym[0], SYM_K);
            chk("ack_sync6_K", obs_sym[6], SYM_K);
            chk("ack_sync7_K", obs_sym[7], SYM_K);
        end
        compare_run("ack");

        // all ones: stuff after the 5th data one
        word_to_q(32'hFF, 8, pk);
        add_packet(pk, -1);
        run_stream(-1, -1);
        if (obs_len.size() > 0) chk("ff_oe_20", obs_len[0], 20);
        chk("ff_ready_8", obs_ready, 8);
        compare_run("ff");

        // trailing six ones: stuffed zero before EOP
        word_to_q(32'hFC00, 16, pk);
        add_packet(pk, -1);
        run_stream(-1, -1);
        if (obs_len.size() > 0) chk("fc00_oe_28", obs_len[0], 28);
        compare_run("fc00");

        // underrun after 3 data bits
        word_to_q(32'h5A5A, 16, pk);
        add_packet(pk, 3);
        run_stream(3, -1);
        chk("abort_underrun_1", obs_under, 1);
        compare_run("abort");

        // reset at bit 4, then a clean ACK
        word_to_q(32'h1234, 16, pk);
        foreach (pk[i]) begin
            q_bits.push_back(pk[i]);
            q_last.push_back(i == 15);
        end
        run_stream(-1, 4);
        clear_all();
        word_to_q(32'hD2, 8, pk);
        add_packet(pk, -1);
        run_stream(-1, -1);
        compare_run("post_rst_ack");

        // two ACKs back-to-back, in_valid held
        word_to_q(32'hD2, 8, pk);
        add_packet(pk, -1);
        add_packet(pk, -1);
        exp_gaps = 1;
        run_stream(-1, -1);
        compare_run("b2b_ack");

        // randomized packets
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 24);
            pk = {};
            for (int i = 0; i < n; i++) pk.push_back($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            add_packet(pk, ab);
            if (ab < 0 && $urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 16);
                pk = {};
                for (int i = 0; i < n; i++) pk.push_back($urandom_range(0, 2) != 0);
                add_packet(pk, -1);
                exp_gaps = 1;
            end
            run_stream(ab, -1);
            compare_run("rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_tx_bitstuff_nrzi.md
Name: usb_tx_bitstuff_nrzi

Overview:
- Transmit-side serialiser in the USB host datapath, directly downstream of the packet/CRC encoder; it drives the host's D+/D- wires that the thumbDrive device model samples.
- Consumes a bit-serial packet body (PID, payload and CRC, LSB-first) over a valid/ready handshake.
- Prepends SYNC, applies bit stuffing and NRZI encoding, and appends EOP (SE0 followed by J).
- Bit rate is one bit per clk.

Parameters:
SYNC_BITS, 8, length of the SYNC field: SYNC_BITS-1 zeros, then a single one
STUFF_LIMIT, 6, consecutive ones after which a zero is inserted
EOP_SE0_CYCLES, 2, number of SE0 bit times in EOP

Ports:
clk  input  1  clock, one bit time per cycle
rst  input  1  asynchronous, active-high reset
in_bit  input  1  next unencoded packet bit
in_valid  input  1  in_bit is valid; also requests packet start when idle
in_last  input  1  qualifies in_bit as the final bit of the packet
in_ready  output  1  block accepts in_bit on this edge
dp  output  1  D+ line (registered)
dm  output  1  D- line (registered)
out_en  output  1  host is driving the bus (registered)
busy  output  1  state != IDLE
underrun  output  1  one-cycle pulse: in_valid dropped mid-packet

Behaviour:
- Reset (asynchronous, any state, including mid-packet):
  - state=IDLE; dp=1, dm=0 (J); out_en=0; in_ready=0; underrun=0.
  - Ones counter=0; NRZI level=J.
- Line encoding: J = dp1/dm0, K = dp0/dm1, SE0 = dp0/dm0.
- NRZI: a 0 toggles J<->K; a 1 holds the level. Every wire value is registered and appears the cycle after the edge that encoded it.
- States and transitions:
  - IDLE: drive J, out_en=0, in_ready=0. If in_valid=1 at the edge, go to SYNC.
  - SYNC: emit SYNC_BITS bits, one per cycle. The bit counter wraps from SYNC_BITS-1 to DATA. out_en=1 from the first SYNC bit. The final SYNC 1 seeds the ones counter to 1.
  - DATA: in_ready=1 combinationally when state==DATA.
    - Handshake (in_valid&in_ready) encodes in_bit. A 1 increments the ones counter; a 0 clears it.
    - If the counter reaches STUFF_LIMIT, go to STUFF.
    - Else if in_last=1, go to EOP_SE0; otherwise stay in DATA.
    - If in_valid=0 while in DATA: pulse underrun for 1 cycle and go to EOP_SE0 (packet aborted). No bit is emitted that cycle.
  - STUFF: in_ready=0. Emit an encoded 0 (toggle) and clear the counter. Return to DATA, or to EOP_SE0 if the bit that triggered the stuff carried in_last. A stuffed 0 is always inserted, even after the final bit.
  - EOP_SE0: drive SE0 for EOP_SE0_CYCLES cycles.
  - EOP_J: drive J for 1 cycle with out_en=1, then go to IDLE. out_en falls the following cycle. NRZI level resets to J.
- Back-to-back packets: IDLE is always occupied for at least 1 cycle between packets. busy is low for exactly 1 cycle when in_valid is held.
- Handshake and counting rules:
  - in_last without in_valid is ignored.
  - in_bit and in_last are sampled only on a handshake.
  - The ones counter is 3 bits wide and never exceeds STUFF_LIMIT.

Decomposition:
- usb_pkg holds:
  - the tx_state_t enum (IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J);
  - line constants J, K, SE0 as 2-bit {dp,dm};
  - the default SYNC_BITS, STUFF_LIMIT and EOP_SE0_CYCLES values.
- Sub-module usb_nrzi_enc holds the NRZI level register and the {dp,dm,out_en} output registers.
  - Inputs: bit, bit_en, force_se0, force_j, drive.
  - Resets to J with drive off.

Test Plan:
- ACK packet, body 8'hD2 sent LSB-first (0,1,0,0,1,0,1,1) with in_last on the 8th bit:
  - out_en high exactly 19 cycles (8 SYNC + 8 data + 2 SE0 + 1 J).
  - in_ready high exactly 8 cycles.
  - SYNC wire sequence K,J,K,J,K,J,K,K.
  - No stuff is inserted.
- Body 8'hFF, last on bit 8:
  - The SYNC 1 counts toward the run, so a stuffed 0 is inserted after the 5th data one and in_ready is low for that cycle.
  - Data phase lasts 9 cycles.
  - Line holds for 6 bit times, then toggles.
- 16-bit body ending in six ones (16'hFC00, LSB-first) with in_last on the 6th one:
  - A stuffed 0 (one toggle) precedes the 2 SE0 cycles.
  - out_en high 8+16+1+3 = 28 cycles.
- Drop in_valid for 1 cycle after 3 data bits:
  - underrun pulses once.
  - SE0 begins the next cycle, followed by J.
  - IDLE is reached 3 cycles after the drop.
- Assert rst mid-DATA (bit 4 of a 16-bit body):
  - dp=1, dm=0, out_en=0, busy=0 immediately, without waiting for a clk edge.
  - The next packet after reset transmits a correct SYNC starting from J.
- Two ACK packets back-to-back with in_valid held high:
  - busy low exactly 1 cycle between them.
  - Each packet's wire sequence is identical to the single-ACK case.
